// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: EX-stage sequencer for DIV/DIVU/REM/REMU around an iterative divider.
module muldiv_issue_ctrl #(
  parameter int XLEN        = 32,
  parameter int DIV_TIMEOUT = 48
) (
  input  logic            sys_clk,
  input  logic            sys_reset_n,
  input  logic            op_valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            wb_valid_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      wb_rd_o,
  output logic            timeout_o,
  output logic            div_start_o,
  output logic [XLEN-1:0] div_dividend_o,
  output logic [XLEN-1:0] div_divisor_o,
  output logic [2:0]      div_funct3_o,
  input  logic [XLEN-1:0] div_result_i,
  input  logic            div_complete_i
);
  localparam int CW = $clog2(DIV_TIMEOUT + 1);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] res, res_nx;
  logic [4:0] rd_q;
  logic [CW-1:0] cnt;
  logic accept, dz, ovf, to_hit, set_to, stall;
  assign accept = state == IDLE && op_valid_i && funct3_i[2] && !flush_i;
  assign dz     = rs2_i == '0;
  assign ovf    = !funct3_i[0] && rs1_i == MINV && rs2_i == '1;
  assign to_hit = cnt >= CW'(DIV_TIMEOUT - 1);
  always_comb begin
    state_nx = state;
    res_nx   = res;
    set_to   = 1'b0;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        stall = accept;
        if (accept && (dz || ovf)) begin
          state_nx = RESP;
          res_nx   = dz ? (funct3_i[1] ? rs1_i : '1) : (funct3_i[1] ? '0 : MINV);
        end else if (accept) state_nx = ISSUE;
      end
      ISSUE: begin
        stall    = !flush_i;
        state_nx = flush_i ? DRAIN : WAIT;
      end
      WAIT: begin
        stall = !flush_i;
        if (flush_i) state_nx = div_complete_i ? IDLE : DRAIN;
        else if (div_complete_i) begin
          state_nx = RESP;
          res_nx   = div_result_i;
        end else if (to_hit) begin
          state_nx = RESP;
          res_nx   = '0;
          set_to   = 1'b1;
        end
      end
      RESP: begin
        stall    = 1'b1;
        state_nx = IDLE;
      end
      DRAIN: begin
        stall    = op_valid_i && funct3_i[2];
        state_nx = (div_complete_i || to_hit) ? IDLE : DRAIN;
        set_to   = !div_complete_i && to_hit;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state          <= IDLE;
      res            <= '0;
      rd_q           <= '0;
      cnt            <= '0;
      timeout_o      <= 1'b0;
      div_dividend_o <= '0;
      div_divisor_o  <= '0;
      div_funct3_o   <= '0;
    end else begin
      state <= state_nx;
      res   <= res_nx;
      if (set_to) timeout_o <= 1'b1;
      if (accept) begin
        div_dividend_o <= rs1_i;
        div_divisor_o  <= rs2_i;
        div_funct3_o   <= funct3_i;
        rd_q           <= rd_i;
        cnt            <= '0;
      end else if ((state == WAIT || state == DRAIN) && !to_hit) cnt <= cnt + 1'b1;
    end
  end
  // stall is combinational from the inputs, so gate it to honour the async reset immediately
  assign stall_o     = stall && sys_reset_n;
  assign wb_valid_o  = state == RESP;
  assign wb_data_o   = wb_valid_o ? res : '0;
  assign wb_rd_o     = wb_valid_o ? rd_q : '0;
  assign div_start_o = state == ISSUE;
endmodule
